// File: rtl/zbt_image_writer.sv
// Packs a stream of pixel bytes into 36-bit ZBT write words, four bytes per word.
// Optional even parity per byte lane in [35:32] when ZBT_WRITER_PARITY_EN is defined.
module zbt_image_writer #(
    parameter int BYTE_ORDER = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  image_data,
    input  logic        new_input,
    output logic        new_output,
    output logic [35:0] image_data_zbt
);

    logic [1:0]  r_count;
    logic [31:0] r_assembly;
    logic [35:0] r_zbt;
    logic        r_new_output;

    logic [1:0]  w_lane;
    logic [31:0] w_merged;
    logic [3:0]  w_pad;

`ifdef ZBT_WRITER_PARITY_EN
    function automatic logic [3:0] lane_parity(input logic [31:0] word);
        return {^word[31:24], ^word[23:16], ^word[15:8], ^word[7:0]};
    endfunction

    assign w_pad = lane_parity(w_merged);
`else
    assign w_pad = 4'b0000;
`endif

    // Lane select: order 0 fills from the top byte down, order 1 from the bottom up.
    always_comb begin
        w_lane = r_count;
        if (BYTE_ORDER == 0) begin
            w_lane = 2'd3 - r_count;
        end else begin
            w_lane = r_count;
        end
    end

    // Assembly register with the current byte dropped into its lane; on the fourth
    // byte this is the complete word, so it is captured straight into the output.
    always_comb begin
        w_merged = r_assembly;
        w_merged[{w_lane, 3'b000} +: 8] = image_data;
    end

    // Byte counter, assembly register and registered output word/pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= 2'd0;
            r_assembly   <= 32'd0;
            r_zbt        <= 36'd0;
            r_new_output <= 1'b0;
        end else if (new_input) begin
            r_assembly <= w_merged;
            r_count    <= r_count + 2'd1;
            if (r_count == 2'd3) begin
                r_zbt        <= {w_pad, w_merged};
                r_new_output <= 1'b1;
            end else begin
                r_new_output <= 1'b0;
            end
        end else begin
            r_new_output <= 1'b0;
        end
    end

    assign new_output     = r_new_output;
    assign image_data_zbt = r_zbt;

endmodule

// File: tb/tb_zbt_image_writer.sv
// Scoreboard bench for zbt_image_writer: two instances (BYTE_ORDER 0 and 1) share inputs.
module tb_zbt_image_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  image_data = 8'h00;
    logic        new_input = 1'b0;
    logic        nout0, nout1;
    logic [35:0] zbt0, zbt1;

    zbt_image_writer #(.BYTE_ORDER(0)) dut0 (
        .clk(clk), .reset(reset), .image_data(image_data), .new_input(new_input),
        .new_output(nout0), .image_data_zbt(zbt0)
    );

    zbt_image_writer #(.BYTE_ORDER(1)) dut1 (
        .clk(clk), .reset(reset), .image_data(image_data), .new_input(new_input),
        .new_output(nout1), .image_data_zbt(zbt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [35:0] w0;
        logic [35:0] w1;
        int          at;
    } exp_t;

    exp_t        sb[$];
    logic [35:0] last0 = 36'd0;
    logic [35:0] last1 = 36'd0;
    int          vectors = 0;
    int          errors = 0;
    int          nbytes = 0;
    logic [7:0]  held [0:2];

    function automatic logic [35:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input bit rev);
        logic [31:0] d;
        logic [3:0]  p;
        d = rev ? {b3, b2, b1, b0} : {b0, b1, b2, b3};
        p = 4'b0000;
`ifdef ZBT_WRITER_PARITY_EN
        p = {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
`endif
        return {p, d};
    endfunction

    // Drives one byte for one clock, starting and ending at a falling edge.
    task automatic put(input logic [7:0] b);
        exp_t e;
        image_data = b;
        new_input  = 1'b1;
        if (nbytes == 3) begin
            e.w0 = pack(held[0], held[1], held[2], b, 1'b0);
            e.w1 = pack(held[0], held[1], held[2], b, 1'b1);
            e.at = cyc + 1;
            sb.push_back(e);
            nbytes = 0;
        end else begin
            held[nbytes] = b;
            nbytes++;
        end
        @(negedge clk);
        new_input = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        gap(3);
        vectors++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard: every pulse pops one expected word; between pulses the word must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            vectors++;
            if (nout0 || nout1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: cyc %0d nout0=%b nout1=%b, required no pulse",
                             cyc, nout0, nout1);
                end else begin
                    e = sb.pop_front();
                    if (nout0 !== 1'b1 || nout1 !== 1'b1 || zbt0 !== e.w0 || zbt1 !== e.w1
                        || cyc !== e.at) begin
                        errors++;
                        $display("FAIL word: cyc %0d p=%b%b w0=%h w1=%h, required cyc %0d p=11 w0=%h w1=%h",
                                 cyc, nout0, nout1, zbt0, zbt1, e.at, e.w0, e.w1);
                    end
                    last0 = e.w0;
                    last1 = e.w1;
                end
            end else begin
                if (zbt0 !== last0 || zbt1 !== last1) begin
                    errors++;
                    $display("FAIL hold: cyc %0d w0=%h w1=%h, required w0=%h w1=%h",
                             cyc, zbt0, zbt1, last0, last1);
                end
                if (sb.size() != 0 && cyc >= sb[0].at) begin
                    errors++;
                    $display("FAIL missed_pulse: cyc %0d no pulse, required pulse at cyc %0d",
                             cyc, sb[0].at);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic test_reset();
        reset      = 1'b1;
        new_input  = 1'b1;
        image_data = 8'h5A;
        gap(3);
        vectors++;
        if (nout0 !== 1'b0 || nout1 !== 1'b0 || zbt0 !== 36'd0 || zbt1 !== 36'd0) begin
            errors++;
            $display("FAIL reset_state: p=%b%b w0=%h w1=%h, required all 0", nout0, nout1, zbt0, zbt1);
        end
        new_input = 1'b0;
        nbytes    = 0;
        last0     = 36'd0;
        last1     = 36'd0;
        reset     = 1'b0;
        gap(10);
    endtask

    task automatic test_basic();
        put(8'hAA); gap(1);
        put(8'hBB); gap(1);
        put(8'hCC); gap(1);
        put(8'hDD); gap(1);
        vectors++;
        if (zbt0 !== 36'h0AABBCCDD || zbt1 !== 36'h0DDCCBBAA) begin
            errors++;
            $display("FAIL basic: w0=%h w1=%h, required 0aabbccdd 0ddccbbaa", zbt0, zbt1);
        end
        drain("basic");
    endtask

    task automatic test_reverse();
        gap(5);
        put(8'hDD); gap(1);
        put(8'hCC); gap(1);
        put(8'hBB); gap(1);
        put(8'hAA); gap(1);
        vectors++;
        if (zbt0 !== 36'h0DDCCBBAA) begin
            errors++;
            $display("FAIL reverse: w0=%h, required 0ddccbbaa", zbt0);
        end
        drain("reverse");
    endtask

    task automatic test_parity();
        logic [35:0] req;
`ifdef ZBT_WRITER_PARITY_EN
        req = 36'hFABABDCDC;
`else
        req = 36'h0ABABDCDC;
`endif
        put(8'hAB); gap(2);
        put(8'hAB);
        put(8'hDC); gap(4);
        put(8'hDC); gap(1);
        vectors++;
        if (zbt0 !== req) begin
            errors++;
            $display("FAIL parity: w0=%h, required %h", zbt0, req);
        end
        drain("parity");
    endtask

    task automatic test_back_to_back();
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        vectors++;
        if (nout0 !== 1'b1 || zbt0 !== 36'h001020304) begin
            errors++;
            $display("FAIL b2b_first: p=%b w0=%h, required 1 001020304", nout0, zbt0);
        end
        put(8'h05);
        vectors++;
        if (nout0 !== 1'b0 || zbt0 !== 36'h001020304) begin
            errors++;
            $display("FAIL b2b_after_first: p=%b w0=%h, required 0 001020304", nout0, zbt0);
        end
        put(8'h06); put(8'h07); put(8'h08);
        vectors++;
        if (nout0 !== 1'b1 || zbt0 !== 36'h005060708) begin
            errors++;
            $display("FAIL b2b_second: p=%b w0=%h, required 1 005060708", nout0, zbt0);
        end
        drain("b2b");
    endtask

    task automatic test_reset_midword();
        put(8'h77); gap(1);
        put(8'h88); gap(1);
        reset = 1'b1;
        #1;
        vectors++;
        if (nout0 !== 1'b0 || zbt0 !== 36'd0 || zbt1 !== 36'd0) begin
            errors++;
            $display("FAIL midword_async: p=%b w0=%h w1=%h, required 0", nout0, zbt0, zbt1);
        end
        @(negedge clk);
        new_input  = 1'b1;
        image_data = 8'h99;
        gap(2);
        vectors++;
        if (nout0 !== 1'b0 || nout1 !== 1'b0 || zbt0 !== 36'd0 || zbt1 !== 36'd0) begin
            errors++;
            $display("FAIL midword_held: p=%b%b w0=%h w1=%h, required 0", nout0, nout1, zbt0, zbt1);
        end
        new_input = 1'b0;
        nbytes    = 0;
        sb.delete();
        last0     = 36'd0;
        last1     = 36'd0;
        reset     = 1'b0;
        gap(2);
        put(8'h11); gap(1);
        put(8'h22); gap(1);
        put(8'h33); gap(1);
        put(8'h44); gap(1);
        vectors++;
        if (zbt0 !== 36'h011223344 || zbt1 !== 36'h044332211) begin
            errors++;
            $display("FAIL midword_word: w0=%h w1=%h, required 011223344 044332211", zbt0, zbt1);
        end
        drain("midword");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            put(8'($urandom_range(255, 0)));
            if ($urandom_range(1, 0) == 1) gap(int'($urandom_range(3, 1)));
        end
        while (nbytes != 0) put(8'hE5);
        drain("random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reverse();
        test_parity();
        test_back_to_back();
        test_reset_midword();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
